// File: rtl/ata_sector_reader_if.sv
// Request/status, byte-stream and ATA pass-through signals of the sector reader.
// master: the read engine; slave: the surrounding system (requester, consumer, boot port).
interface ata_sector_reader_if;
  logic        boot_done;
  logic        req;
  logic [27:0] lba;
  logic [7:0]  count;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        ata_cs;
  logic [2:0]  ata_adr;
  logic        ata_iord;
  logic        ata_iowr;
  logic [7:0]  ata_wdata;
  logic [7:0]  ata_rdata;

  modport master (
    input  boot_done, req, lba, count, out_ready, ata_rdata,
    output busy, done, err, err_code, out_valid, out_data,
           ata_cs, ata_adr, ata_iord, ata_iowr, ata_wdata
  );

  modport slave (
    output boot_done, req, lba, count, out_ready, ata_rdata,
    input  busy, done, err, err_code, out_valid, out_data,
           ata_cs, ata_adr, ata_iord, ata_iowr, ata_wdata
  );
endinterface

// File: rtl/ata_sector_reader.sv
// Multi-sector ATA/CF READ SECTORS engine (8-bit PIO, LBA28) on the boot pass-through port.
// Define ATA_RD_TIMEOUT_EN to fail with err_code=2 after POLL_LIMIT busy status polls.
module ata_sector_reader #(
  parameter int STROBE_CYCLES = 8,
  parameter int GAP_CYCLES    = 2,
  parameter int POLL_LIMIT    = 65535
) (
  input  logic                clk,
  input  logic                reset,
  ata_sector_reader_if.master bus
);

  if (STROBE_CYCLES < 6 || GAP_CYCLES < 1 || POLL_LIMIT < 1 || POLL_LIMIT > 65535) begin : g_bad_params
    $error("ata_sector_reader: parameter out of range");
  end

  localparam logic [15:0] STROBE_LAST = 16'(STROBE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {A_IDLE, A_STROBE, A_HOLD, A_GAP} acc_t;
  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_WAIT_RDY, S_SETUP, S_WAIT_DRQ, S_DATA, S_OUT, S_DONE, S_FAIL
  } state_t;

  acc_t        phase_q, phase_d;
  logic [15:0] acc_cnt_q;
  logic [2:0]  adr_q;
  logic [7:0]  wdata_q, rdata_q;
  logic        wr_q;
  logic        acc_start, acc_wr, acc_done, need_acc;
  logic [2:0]  acc_adr;
  logic [7:0]  acc_wdata;

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic        init_done;
  logic [27:0] lba_q;
  logic [7:0]  count_q;
  logic [8:0]  sect_q, byte_q;
  logic [1:0]  err_code_q, fail_code;
  logic        accept, byte_step, poll_expired;

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      A_IDLE:   if (acc_start) phase_d = A_STROBE;
      A_STROBE: if (acc_cnt_q == STROBE_LAST) phase_d = A_HOLD;
      A_HOLD:   phase_d = A_GAP;
      A_GAP:    if (acc_cnt_q == GAP_LAST) phase_d = A_IDLE;
      default:  phase_d = A_IDLE;
    endcase
  end

  assign acc_done = (phase_q == A_GAP) && (acc_cnt_q == GAP_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= A_IDLE;
      acc_cnt_q <= '0;
      adr_q     <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      rdata_q   <= '0;
    end else begin
      phase_q   <= phase_d;
      acc_cnt_q <= (phase_d != phase_q) ? '0 : acc_cnt_q + 16'd1;
      if (phase_q == A_IDLE && acc_start) begin
        adr_q   <= acc_adr;
        wdata_q <= acc_wdata;
        wr_q    <= acc_wr;
      end
      // Data is captured at the end of the cs-only hold clock, after the strobe has gone.
      if (phase_q == A_HOLD) rdata_q <= bus.ata_rdata;
    end
  end

  assign bus.ata_cs    = (phase_q == A_STROBE) || (phase_q == A_HOLD);
  assign bus.ata_iord  = (phase_q == A_STROBE) && !wr_q;
  assign bus.ata_iowr  = (phase_q == A_STROBE) && wr_q;
  assign bus.ata_adr   = adr_q;
  assign bus.ata_wdata = wdata_q;

`ifdef ATA_RD_TIMEOUT_EN
  localparam logic [15:0] POLL_LAST = 16'(POLL_LIMIT - 1);
  logic [15:0] poll_q;

  always_ff @(posedge clk) begin
    if (reset)
      poll_q <= '0;
    else if ((state_d == S_WAIT_RDY || state_d == S_WAIT_DRQ) && state_d != state_q)
      poll_q <= '0;
    else if (acc_done && (state_q == S_WAIT_RDY || state_q == S_WAIT_DRQ))
      poll_q <= poll_q + 16'd1;
  end

  assign poll_expired = (poll_q == POLL_LAST);
`else
  assign poll_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    accept    = 1'b0;
    byte_step = 1'b0;
    fail_code = 2'd0;
    need_acc  = 1'b0;
    acc_wr    = 1'b0;
    acc_adr   = 3'd0;
    acc_wdata = 8'h00;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        state_d = S_IDLE;
        if (bus.req && bus.boot_done) begin
          accept  = 1'b1;
          step_d  = 3'd0;
          state_d = init_done ? S_WAIT_RDY : S_INIT;
        end
      end
      S_INIT: begin
        need_acc  = 1'b1;
        acc_wr    = 1'b1;
        acc_adr   = step_q[0] ? 3'd7 : 3'd1;
        acc_wdata = step_q[0] ? 8'hEF : 8'h01;
        if (acc_done) begin
          if (step_q[0]) begin
            state_d = S_WAIT_RDY;
            step_d  = 3'd0;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
      S_WAIT_RDY: begin
        need_acc = 1'b1;
        acc_adr  = 3'd7;
        if (acc_done) begin
          if (!rdata_q[7]) begin
            state_d = S_SETUP;
          end else if (poll_expired) begin
            state_d   = S_FAIL;
            fail_code = 2'd2;
          end
        end
      end
      S_SETUP: begin
        need_acc = 1'b1;
        acc_wr   = 1'b1;
        acc_adr  = step_q + 3'd2;
        case (step_q)
          3'd0:    acc_wdata = count_q;
          3'd1:    acc_wdata = lba_q[7:0];
          3'd2:    acc_wdata = lba_q[15:8];
          3'd3:    acc_wdata = lba_q[23:16];
          3'd4:    acc_wdata = {4'hE, lba_q[27:24]};
          default: acc_wdata = 8'h20;
        endcase
        if (acc_done) begin
          if (step_q == 3'd5) begin
            state_d = S_WAIT_DRQ;
            step_d  = 3'd0;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
      S_WAIT_DRQ: begin
        need_acc = 1'b1;
        acc_adr  = 3'd7;
        if (acc_done) begin
          if (!rdata_q[7] && rdata_q[0]) begin
            state_d   = S_FAIL;
            fail_code = 2'd1;
          end else if (!rdata_q[7] && rdata_q[3]) begin
            state_d = S_DATA;
          end else if (poll_expired) begin
            state_d   = S_FAIL;
            fail_code = 2'd2;
          end
        end
      end
      S_DATA: begin
        need_acc = 1'b1;
        if (acc_done) state_d = S_OUT;
      end
      S_OUT: begin
        if (!bus.boot_done) begin
          state_d   = S_FAIL;
          fail_code = 2'd2;
        end else if (bus.out_ready) begin
          byte_step = 1'b1;
          if (byte_q == 9'd511)
            state_d = (sect_q == 9'd1) ? S_DONE : S_WAIT_DRQ;
          else
            state_d = S_DATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Losing boot_done only takes effect between accesses, never cutting one short.
    if (need_acc && !bus.boot_done && (acc_done || phase_q == A_IDLE)) begin
      state_d   = S_FAIL;
      fail_code = 2'd2;
    end
    acc_start = need_acc && bus.boot_done && (phase_q == A_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      init_done  <= 1'b0;
      lba_q      <= '0;
      count_q    <= '0;
      sect_q     <= '0;
      byte_q     <= '0;
      err_code_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      if (accept) begin
        lba_q      <= bus.lba;
        count_q    <= bus.count;
        sect_q     <= (bus.count == 8'd0) ? 9'd256 : {1'b0, bus.count};
        byte_q     <= '0;
        err_code_q <= 2'd0;
      end
      if (state_q == S_INIT && state_d == S_WAIT_RDY) init_done <= 1'b1;
      if (byte_step) begin
        byte_q <= byte_q + 9'd1;
        if (byte_q == 9'd511) sect_q <= sect_q - 9'd1;
      end
      if (state_d == S_FAIL && state_q != S_FAIL) err_code_q <= fail_code;
    end
  end

  assign bus.busy      = !(state_q inside {S_IDLE, S_DONE, S_FAIL});
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = (state_q == S_FAIL);
  assign bus.err_code  = err_code_q;
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_data  = rdata_q;

endmodule

// File: tb/tb_ata_sector_reader.sv
// Bench for ata_sector_reader: a CF register model on the pass-through port plus
// scoreboards for expected register writes and streamed bytes.
module tb_ata_sector_reader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ata_sector_reader_if bus();

  ata_sector_reader #(
    .STROBE_CYCLES(6),
    .GAP_CYCLES   (1),
    .POLL_LIMIT   (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] pat(input logic [27:0] s, input logic [8:0] i);
    return s[7:0] ^ s[15:8] ^ i[7:0] ^ {i[8], 7'h2B};
  endfunction

  // CF card model
  logic [7:0]  status = 8'h58;
  logic [7:0]  regs [8];
  logic [27:0] sec_cur = '0;
  logic [8:0]  idx = '0;
  logic        prev_cs = 1'b0;
  logic        saw_wr = 1'b0;
  int reg0_reads = 0, status_reads = 0, bytes_seen = 0;
  int done_cnt = 0, err_cnt = 0, valid_seen = 0;

  logic [11:0] exp_wr [$];
  logic [8:0]  exp_q  [$];
  logic [11:0] ew;
  logic [8:0]  eb;

  always_comb begin
    if (bus.ata_adr == 3'd0)      bus.ata_rdata = pat(sec_cur, idx);
    else if (bus.ata_adr == 3'd7) bus.ata_rdata = status;
    else                          bus.ata_rdata = 8'h00;
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_cs = 1'b0;
      saw_wr  = 1'b0;
    end else begin
      if (bus.ata_iowr) saw_wr = 1'b1;
      if (prev_cs && !bus.ata_cs) begin
        if (saw_wr) begin
          ew = (exp_wr.size() != 0) ? exp_wr.pop_front() : 12'hFFF;
          check("reg_write", {1'b0, bus.ata_adr, bus.ata_wdata}, ew);
          regs[bus.ata_adr] = bus.ata_wdata;
          if (bus.ata_adr == 3'd7 && bus.ata_wdata == 8'h20) begin
            sec_cur = {regs[6][3:0], regs[5], regs[4], regs[3]};
            idx     = '0;
          end
        end else if (bus.ata_adr == 3'd0) begin
          reg0_reads++;
          if (idx == 9'd511) sec_cur = sec_cur + 28'd1;
          idx = idx + 9'd1;
        end else if (bus.ata_adr == 3'd7) begin
          status_reads++;
        end
        saw_wr = 1'b0;
      end
      prev_cs = bus.ata_cs;
      if (bus.out_valid) valid_seen++;
      if (bus.out_valid && bus.out_ready) begin
        eb = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h100;
        check("byte", {1'b0, bus.out_data}, eb);
        bytes_seen++;
      end
      if (bus.done) begin
        done_cnt++;
        check("busy_at_done", bus.busy, 0);
      end
      if (bus.err) begin
        err_cnt++;
        check("busy_at_err", bus.busy, 0);
      end
    end
  end

  task automatic issue(input logic [27:0] a, input logic [7:0] c, input bit with_init,
                       input bit with_setup, input int unsigned n_bytes);
    if (with_init) begin
      exp_wr.push_back({1'b0, 3'd1, 8'h01});
      exp_wr.push_back({1'b0, 3'd7, 8'hEF});
    end
    if (with_setup) begin
      exp_wr.push_back({1'b0, 3'd2, c});
      exp_wr.push_back({1'b0, 3'd3, a[7:0]});
      exp_wr.push_back({1'b0, 3'd4, a[15:8]});
      exp_wr.push_back({1'b0, 3'd5, a[23:16]});
      exp_wr.push_back({1'b0, 3'd6, 4'hE, a[27:24]});
      exp_wr.push_back({1'b0, 3'd7, 8'h20});
    end
    for (int unsigned k = 0; k < n_bytes; k++)
      exp_q.push_back({1'b0, pat(a + 28'(k / 512), 9'(k % 512))});
    bytes_seen = 0; status_reads = 0; reg0_reads = 0;
    valid_seen = 0; done_cnt = 0; err_cnt = 0;
    bus.lba = a; bus.count = c; bus.req = 1'b1;
    @(posedge clk); #1;
    bus.req = 1'b0;
    check("busy_on_accept", bus.busy, 1);
  endtask

  task automatic pump(input int stop_bytes, input int max_cycles);
    int d0, e0;
    bit timed_out;
    d0 = done_cnt; e0 = err_cnt; timed_out = 1'b1;
    for (int unsigned i = 0; i < max_cycles; i++) begin
      @(posedge clk); #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (done_cnt != d0 || err_cnt != e0 || bytes_seen >= stop_bytes) begin
        timed_out = 1'b0;
        break;
      end
    end
    check("pump_budget", timed_out, 0);
  endtask

  int   r0;
  bit   found;
  logic [8:0] head;

  initial begin
    bus.req = 1'b0; bus.lba = '0; bus.count = '0;
    bus.boot_done = 1'b0; bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {bus.ata_cs, bus.ata_iord, bus.ata_iowr, bus.busy, bus.done, bus.err, bus.out_valid}, 0);
    check("rst_err_code", bus.err_code, 0);
    check("rst_bus", {bus.ata_adr, bus.ata_wdata, bus.out_data}, 0);
    reset = 1'b0;
    bus.boot_done = 1'b1;
    @(posedge clk); #1;

    // first request: init + one sector, with a 100-clock consumer stall
    status = 8'h58;
    issue(28'h000004D, 8'd1, 1'b1, 1'b1, 512);
    pump(200, 5000);
    bus.out_ready = 1'b0;
    found = 1'b0;
    for (int unsigned i = 0; i < 50; i++) begin
      if (bus.out_valid) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("stall_valid_seen", found, 1);
    head = exp_q[0];
    r0 = reg0_reads;
    repeat (100) @(posedge clk);
    #1;
    check("stall_valid", bus.out_valid, 1);
    check("stall_data", {1'b0, bus.out_data}, head);
    check("stall_no_reg0", reg0_reads - r0, 0);
    pump(1 << 30, 20000);
    check("a_bytes", bytes_seen, 512);
    check("a_done", done_cnt, 1);
    check("a_exp_left", exp_q.size(), 0);
    check("a_wr_left", exp_wr.size(), 0);

    // second request: no init, two sectors, ignored req while busy
    issue(28'h0ABCDEF, 8'd2, 1'b0, 1'b1, 1024);
    pump(300, 8000);
    bus.lba = 28'h0000999; bus.count = 8'd7; bus.req = 1'b1;
    @(posedge clk); #1;
    bus.req = 1'b0;
    pump(1 << 30, 30000);
    check("b_bytes", bytes_seen, 1024);
    check("b_reg0_reads", reg0_reads, 1024);
    check("b_status_reads", status_reads, 3);
    check("b_done", done_cnt, 1);
    check("b_exp_left", exp_q.size(), 0);
    check("b_wr_left", exp_wr.size(), 0);

    // ATA error after the command
    status = 8'h51;
    issue(28'h0000100, 8'd3, 1'b0, 1'b1, 0);
    pump(1 << 30, 2000);
    check("c_err", err_cnt, 1);
    check("c_err_code", bus.err_code, 1);
    check("c_busy", bus.busy, 0);
    check("c_no_valid", valid_seen, 0);
    check("c_no_done", done_cnt, 0);
    check("c_wr_left", exp_wr.size(), 0);

    // boot_done lost mid-transfer
    status = 8'h58;
    issue(28'h0000200, 8'd1, 1'b0, 1'b1, 512);
    pump(50, 3000);
    bus.boot_done = 1'b0;
    pump(1 << 30, 200);
    check("e_err", err_cnt, 1);
    check("e_err_code", bus.err_code, 2);
    check("e_no_done", done_cnt, 0);
    exp_q.delete();
    bus.req = 1'b1;
    @(posedge clk); #1;
    bus.req = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("e_req_ignored", bus.busy, 0);
    check("e_code_held", bus.err_code, 2);
    bus.boot_done = 1'b1;

    // count=0 means 256 sectors: cross two sector boundaries, then reset mid-access
    issue(28'h1234567, 8'd0, 1'b0, 1'b1, 1200);
    pump(1100, 30000);
    check("f_still_busy", bus.busy, 1);
    check("f_no_done", done_cnt, 0);
    check("f_status_reads", status_reads, 4);
    bus.out_ready = 1'b1;
    found = 1'b0;
    for (int unsigned i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (bus.ata_iord) begin found = 1'b1; break; end
    end
    check("f_iord_seen", found, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("f_reset_strobes", {bus.ata_cs, bus.ata_iord, bus.ata_iowr}, 0);
    check("f_reset_state", {bus.busy, bus.out_valid}, 0);
    reset = 1'b0;
    bus.out_ready = 1'b0;
    exp_q.delete();
    check("f_wr_left", exp_wr.size(), 0);
    @(posedge clk); #1;

`ifdef ATA_RD_TIMEOUT_EN
    // stuck BSY: times out after POLL_LIMIT status reads
    status = 8'h80;
    issue(28'h0000005, 8'd1, 1'b1, 1'b0, 0);
    pump(1 << 30, 5000);
    check("g_err", err_cnt, 1);
    check("g_err_code", bus.err_code, 2);
    check("g_status_reads", status_reads, 16);
    check("g_wr_left", exp_wr.size(), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
